// File: rtl/display_sr_gen.sv
// Display shift register: hold / shift / rotate / LFSR with a prescaler.
// Parallel load, LFSR lock-up recovery and sequence-wrap pulse.
module display_sr_gen #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
  parameter logic [WIDTH-1:0] SEED  = 8'h01,
  parameter int               DIV   = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             sin,
  output logic [WIDTH-1:0] qs,
  output logic             step,
  output logic             wrap,
  output logic             lockup
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DIV - 1);

  localparam logic [1:0] M_HOLD  = 2'b00;
  localparam logic [1:0] M_SHIFT = 2'b01;
  localparam logic [1:0] M_ROT   = 2'b10;
  localparam logic [1:0] M_LFSR  = 2'b11;

  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic             tick;
  logic             fb;
  logic             zero;
  logic [WIDTH-1:0] nxt;

  assign tick = en && (cnt == CMAX);
  assign fb   = ^(qs & TAPS);
  assign zero = (qs == '0);

  always_comb begin
    cnt_nxt = cnt;
    if (en) begin
      if (tick) cnt_nxt = '0;
      else      cnt_nxt = cnt + CW'(1);
    end
  end

  // an all-zero LFSR would stick forever, so it restarts from SEED
  always_comb begin
    nxt = qs;
    unique case (mode)
      M_HOLD:  nxt = qs;
      M_SHIFT: nxt = {qs[WIDTH-2:0], sin};
      M_ROT:   nxt = {qs[WIDTH-2:0], qs[WIDTH-1]};
      M_LFSR:  nxt = zero ? SEED : {qs[WIDTH-2:0], fb};
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      qs     <= SEED;
      cnt    <= '0;
      step   <= 1'b0;
      wrap   <= 1'b0;
      lockup <= 1'b0;
    end else begin
      step   <= 1'b0;
      wrap   <= 1'b0;
      lockup <= 1'b0;
      if (load) begin
        qs  <= din;
        cnt <= '0;
      end else begin
        cnt <= cnt_nxt;
        if (tick && (mode != M_HOLD)) begin
          qs   <= nxt;
          step <= 1'b1;
          if (mode == M_LFSR) begin
            wrap   <= (nxt == SEED);
            lockup <= zero;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_display_sr_gen.sv
// Bench for display_sr_gen: scoreboard of expected register states,
// one DIV=1 instance and one DIV=4 instance on shared stimulus.
module tb_display_sr_gen;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       load = 1'b0;
  logic [7:0] din = 8'h00;
  logic       sin = 1'b0;

  logic [7:0] qa, qb;
  logic       sa, wa, la;
  logic       sb_, wb, lb;

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit         b;
    logic [7:0] q;
    logic       s;
    logic       w;
    logic       l;
    string      tag;
  } exp_t;

  exp_t sbq[$];

  always #5 clk = ~clk;

  display_sr_gen #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h01), .DIV(1)) u_a (
    .clk(clk), .clr(clr), .en(en), .mode(mode), .load(load),
    .din(din), .sin(sin), .qs(qa), .step(sa), .wrap(wa), .lockup(la)
  );

  display_sr_gen #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h01), .DIV(4)) u_b (
    .clk(clk), .clr(clr), .en(en), .mode(mode), .load(load),
    .din(din), .sin(sin), .qs(qb), .step(sb_), .wrap(wb), .lockup(lb)
  );

  function automatic logic [7:0] lfsr(input logic [7:0] x);
    return {x[6:0], ^(x & 8'hB8)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input bit b, input logic [7:0] q, input logic s,
                      input logic w, input logic l, input string tag);
    exp_t e;
    e.b = b; e.q = q; e.s = s; e.w = w; e.l = l; e.tag = tag;
    sbq.push_back(e);
  endtask

  // advance one clock and score the oldest expectation
  task automatic cyc();
    exp_t e;
    @(posedge clk);
    #1;
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      if (e.b) begin
        chk({e.tag, ".qs"}, 32'(qb), 32'(e.q));
        chk({e.tag, ".step"}, 32'(sb_), 32'(e.s));
        chk({e.tag, ".wrap"}, 32'(wb), 32'(e.w));
        chk({e.tag, ".lockup"}, 32'(lb), 32'(e.l));
      end else begin
        chk({e.tag, ".qs"}, 32'(qa), 32'(e.q));
        chk({e.tag, ".step"}, 32'(sa), 32'(e.s));
        chk({e.tag, ".wrap"}, 32'(wa), 32'(e.w));
        chk({e.tag, ".lockup"}, 32'(la), 32'(e.l));
      end
    end
  endtask

  task automatic step_a(input logic [7:0] q, input logic s, input logic w,
                        input logic l, input string tag);
    push(1'b0, q, s, w, l, tag);
    cyc();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    clr = 1'b0;
    @(posedge clk);
    #1;
    clr = 1'b1;
  endtask

  logic [7:0] m;
  logic [7:0] bq;
  bit         chg;
  logic [7:0] lfsr_vals [5];

  initial begin
    lfsr_vals[0] = 8'h02; lfsr_vals[1] = 8'h04; lfsr_vals[2] = 8'h08;
    lfsr_vals[3] = 8'h11; lfsr_vals[4] = 8'h23;

    #1 clr = 1'b0;
    #20;
    chk("rst.qs_a", 32'(qa), 32'h01);
    chk("rst.qs_b", 32'(qb), 32'h01);
    chk("rst.step", 32'(sa), 32'h0);
    chk("rst.wrap", 32'(wa), 32'h0);
    chk("rst.lockup", 32'(la), 32'h0);

    // DIV=4 prescaler, en dropped for edges 10..12
    @(posedge clk);
    #1;
    mode = 2'b11;
    en = 1'b1;
    clr = 1'b1;
    bq = 8'h01;
    for (int e = 1; e <= 16; e++) begin
      en = !(e >= 10 && e <= 12);
      chg = (e == 4 || e == 8 || e == 15);
      if (chg) bq = lfsr(bq);
      push(1'b1, bq, chg, 1'b0, 1'b0, $sformatf("div4.e%0d", e));
      cyc();
    end
    en = 1'b1;

    // DIV=1 LFSR from reset: wrap exactly at step 255
    do_reset();
    for (int i = 0; i < 5; i++)
      step_a(lfsr_vals[i], 1'b1, 1'b0, 1'b0, $sformatf("lfsr.s%0d", i + 1));
    m = 8'h23;
    for (int n = 6; n <= 255; n++) begin
      m = lfsr(m);
      step_a(m, 1'b1, m == 8'h01, 1'b0, $sformatf("lfsr.s%0d", n));
    end

    load = 1'b1; din = 8'h81; mode = 2'b10;
    step_a(8'h81, 1'b0, 1'b0, 1'b0, "rot.load");
    load = 1'b0;
    step_a(8'h03, 1'b1, 1'b0, 1'b0, "rot.1");
    step_a(8'h06, 1'b1, 1'b0, 1'b0, "rot.2");
    step_a(8'h0C, 1'b1, 1'b0, 1'b0, "rot.3");

    load = 1'b1; din = 8'h00; mode = 2'b01; sin = 1'b1;
    step_a(8'h00, 1'b0, 1'b0, 1'b0, "shf.load");
    load = 1'b0;
    step_a(8'h01, 1'b1, 1'b0, 1'b0, "shf.1");
    step_a(8'h03, 1'b1, 1'b0, 1'b0, "shf.2");
    step_a(8'h07, 1'b1, 1'b0, 1'b0, "shf.3");
    sin = 1'b0;
    step_a(8'h0E, 1'b1, 1'b0, 1'b0, "shf.4");

    load = 1'b1; din = 8'h00; mode = 2'b11;
    step_a(8'h00, 1'b0, 1'b0, 1'b0, "lock.load");
    load = 1'b0;
    step_a(8'h01, 1'b1, 1'b1, 1'b1, "lock.rec");
    step_a(8'h02, 1'b1, 1'b0, 1'b0, "lock.after");

    load = 1'b1; din = 8'h5A;
    step_a(8'h5A, 1'b0, 1'b0, 1'b0, "ldtick");
    load = 1'b0; mode = 2'b00;
    step_a(8'h5A, 1'b0, 1'b0, 1'b0, "hold.1");
    step_a(8'h5A, 1'b0, 1'b0, 1'b0, "hold.2");
    mode = 2'b11;
    step_a(8'hB4, 1'b1, 1'b0, 1'b0, "resume");

    // asynchronous reset between edges
    @(negedge clk);
    clr = 1'b0;
    #1;
    chk("arst.qs", 32'(qa), 32'h01);
    chk("arst.step", 32'(sa), 32'h0);
    chk("arst.wrap", 32'(wa), 32'h0);
    chk("arst.lockup", 32'(la), 32'h0);
    @(posedge clk);
    #1;
    clr = 1'b1;
    step_a(8'h02, 1'b1, 1'b0, 1'b0, "arst.r1");
    step_a(8'h04, 1'b1, 1'b0, 1'b0, "arst.r2");

    chk("sb.empty", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
